// File: rtl/if_fetch_unit.sv
// Instruction fetch engine: one outstanding imem read per PC, small instruction
// queue toward decode, and flush handling that discards queued and in-flight fetches.
module if_fetch_unit #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_stall_o,
    input  logic            flush_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            imem_rsp_err_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [XLEN-1:0] if_pc_o,
    output logic [31:0]     if_instr_o,
    output logic            if_fault_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DROP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

    logic [XLEN-1:0] q_pc_q    [DEPTH];
    logic [31:0]     q_instr_q [DEPTH];
    logic            q_fault_q [DEPTH];

    logic            push_s;
    logic            pop_s;
    logic            clear_s;
    logic            full_s;
    logic [XLEN-1:0] push_pc_s;
    logic [31:0]     push_instr_s;
    logic            push_fault_s;
    logic            req_valid_s;
    logic            stall_s;

    assign full_s           = (count_q == CW'(DEPTH));
    assign pop_s            = (count_q != {CW{1'b0}}) && if_ready_i;
    assign imem_req_valid_o = req_valid_s;
    assign imem_req_addr_o  = pc_i;
    assign pc_stall_o       = stall_s;
    assign if_valid_o       = (count_q != {CW{1'b0}});
    assign if_pc_o          = q_pc_q[rd_ptr_q];
    assign if_instr_o       = q_instr_q[rd_ptr_q];
    assign if_fault_o       = q_fault_q[rd_ptr_q];

    // Fetch FSM next state, request/stall outputs and queue push selection.
    always_comb begin
        state_d      = state_q;
        pend_pc_d    = pend_pc_q;
        req_valid_s  = 1'b0;
        stall_s      = 1'b0;
        push_s       = 1'b0;
        push_pc_s    = pc_i;
        push_instr_s = 32'h0000_0000;
        push_fault_s = 1'b0;
        clear_s      = 1'b0;
        case (state_q)
            ST_START: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (flush_i) begin
                    clear_s = 1'b1;
                end else if (full_s) begin
                    stall_s = 1'b1;
                end else if (pc_i[1:0] != 2'b00) begin
                    // Misaligned PC never reaches memory; it becomes a faulting entry.
                    push_s       = 1'b1;
                    push_fault_s = 1'b1;
                end else begin
                    req_valid_s = 1'b1;
                    stall_s     = !imem_req_ready_i;
                    if (imem_req_ready_i) begin
                        pend_pc_d = pc_i;
                        state_d   = ST_WAIT;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    clear_s = 1'b1;
                    state_d = imem_rsp_valid_i ? ST_IDLE : ST_DROP;
                end else begin
                    stall_s = 1'b1;
                    if (imem_rsp_valid_i) begin
                        push_s       = 1'b1;
                        push_pc_s    = pend_pc_q;
                        push_instr_s = imem_rsp_err_i ? 32'h0000_0000 : imem_rsp_data_i;
                        push_fault_s = imem_rsp_err_i;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d      = ST_WAIT;
                    end
                end
            end
            ST_DROP: begin
                if (flush_i) begin
                    clear_s = 1'b1;
                end else begin
                    stall_s = 1'b1;
                    state_d = imem_rsp_valid_i ? ST_IDLE : ST_DROP;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    // Queue pointer and occupancy update; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_s) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
            if (push_s && !pop_s) begin
                count_d = count_q + CW'(1);
            end else if (pop_s && !push_s) begin
                count_d = count_q - CW'(1);
            end else begin
                count_d = count_q;
            end
        end
    end

    // State, pending PC and queue control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_START;
            pend_pc_q <= {XLEN{1'b0}};
            count_q   <= {CW{1'b0}};
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Queue storage; cleared on reset so the head outputs start at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_q[i]    <= {XLEN{1'b0}};
                q_instr_q[i] <= 32'h0000_0000;
                q_fault_q[i] <= 1'b0;
            end
        end else if (push_s) begin
            q_pc_q[wr_ptr_q]    <= push_pc_s;
            q_instr_q[wr_ptr_q] <= push_instr_s;
            q_fault_q[wr_ptr_q] <= push_fault_s;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: PC register and memory models around the DUT, with a
// transaction-level reference (outstanding/discard flags plus a queue) checked every cycle.
module tb_if_fetch_unit;
    localparam int XLEN  = 64;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc_i;
    logic            pc_stall_o;
    logic            flush_i;
    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_rsp_valid_i;
    logic [31:0]     imem_rsp_data_i;
    logic            imem_rsp_err_i;
    logic            if_valid_o;
    logic            if_ready_i;
    logic [XLEN-1:0] if_pc_o;
    logic [31:0]     if_instr_o;
    logic            if_fault_o;

    always #5 clk = ~clk;

    if_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .pc_stall_o(pc_stall_o), .flush_i(flush_i),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i(imem_rsp_data_i), .imem_rsp_err_i(imem_rsp_err_i),
        .if_valid_o(if_valid_o), .if_ready_i(if_ready_i), .if_pc_o(if_pc_o),
        .if_instr_o(if_instr_o), .if_fault_o(if_fault_o)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    // reference model
    ent_t        m_q[$];
    bit          m_started, m_out, m_drop;
    logic [63:0] m_pend;

    // environment
    logic [63:0] pc_reg, target, mem_addr;
    int          lat, mem_cnt, cyc;
    bit          mem_err, err_knob, rand_err;
    logic [63:0] req_log[$];
    int          req_cyc[$];
    logic [63:0] cons_log[$];

    // samples of the last cycle
    logic        s_req, s_stall, s_ifv, s_fault;
    logic [63:0] s_addr, s_ifpc;
    logic [31:0] s_instr;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] tag(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic cycle();
        bit   e_req, e_stall, hs, ev, do_push;
        ent_t h, p;
        int   sz;
        if (mem_cnt == 1) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = tag(mem_addr);
            imem_rsp_err_i   = mem_err;
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = $urandom;
            imem_rsp_err_i   = 1'($urandom_range(0, 1));
        end
        pc_i = pc_reg;
        @(negedge clk);
        e_req = 1'b0; e_stall = 1'b0; hs = 1'b0; do_push = 1'b0; p = '0;
        if (!rst) begin
            sz = m_q.size();
            ev = (sz != 0);
            h  = ev ? m_q[0] : '0;
            if (!m_started) begin
                m_started = 1'b1;
            end else if (flush_i) begin
                m_q.delete();
                if (m_out) begin
                    if (!imem_rsp_valid_i) m_drop = 1'b1;
                    m_out = 1'b0;
                end
            end else begin
                if (m_drop) begin
                    e_stall = 1'b1;
                    if (imem_rsp_valid_i) m_drop = 1'b0;
                end else if (m_out) begin
                    e_stall = 1'b1;
                    if (imem_rsp_valid_i) begin
                        do_push = 1'b1;
                        p = '{m_pend, imem_rsp_err_i ? 32'h0 : imem_rsp_data_i, imem_rsp_err_i};
                        m_out = 1'b0;
                    end
                end else if (sz == DEPTH) begin
                    e_stall = 1'b1;
                end else if (pc_reg[1:0] != 2'b00) begin
                    do_push = 1'b1;
                    p = '{pc_reg, 32'h0, 1'b1};
                end else begin
                    e_req   = 1'b1;
                    e_stall = !imem_req_ready_i;
                    if (imem_req_ready_i) begin
                        hs = 1'b1; m_out = 1'b1; m_pend = pc_reg;
                    end
                end
                if (ev && if_ready_i) void'(m_q.pop_front());
                if (do_push) m_q.push_back(p);
            end
            chk("req_valid", 64'(imem_req_valid_o), 64'(e_req));
            chk("pc_stall", 64'(pc_stall_o), 64'(e_stall));
            if (e_req) chk("req_addr", imem_req_addr_o, pc_reg);
            chk("if_valid", 64'(if_valid_o), 64'(ev));
            if (ev) begin
                chk("if_pc", if_pc_o, h.pc);
                chk("if_instr", 64'(if_instr_o), 64'(h.instr));
                chk("if_fault", 64'(if_fault_o), 64'(h.fault));
                if (if_ready_i) cons_log.push_back(h.pc);
            end
            if (hs) begin
                req_log.push_back(pc_reg);
                req_cyc.push_back(cyc);
            end
        end
        s_req = imem_req_valid_o; s_stall = pc_stall_o; s_ifv = if_valid_o;
        s_addr = imem_req_addr_o; s_ifpc = if_pc_o; s_instr = if_instr_o; s_fault = if_fault_o;
        @(posedge clk);
        #1;
        if (rst) begin
            m_started = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_pend = '0; m_q.delete();
            pc_reg = 64'hFFFF_FFFF_FFFF_FFFC; mem_cnt = 0;
        end else begin
            if (mem_cnt > 0) mem_cnt--;
            if (hs) begin
                mem_cnt  = lat;
                mem_addr = pc_reg;
                mem_err  = rand_err ? ($urandom_range(0, 9) == 0) : err_knob;
            end
            if (flush_i) pc_reg = target;
            else if (!e_stall) pc_reg = pc_reg + 64'd4;
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush_i = 1'b0; if_ready_i = 1'b1; imem_req_ready_i = 1'b1;
        lat = 1; err_knob = 1'b0; rand_err = 1'b0;
        cycle();
        cycle();
        chk("rst_req_valid", 64'(s_req), 64'd0);
        chk("rst_stall", 64'(s_stall), 64'd0);
        chk("rst_if_valid", 64'(s_ifv), 64'd0);
        chk("rst_if_pc", s_ifpc, 64'd0);
        chk("rst_if_instr", 64'(s_instr), 64'd0);
        chk("rst_if_fault", 64'(s_fault), 64'd0);
        rst = 1'b0;
        req_log.delete(); req_cyc.delete(); cons_log.delete();
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; if_ready_i = 1'b1; imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 32'h0; imem_rsp_err_i = 1'b0;
        pc_reg = 64'hFFFF_FFFF_FFFF_FFFC; pc_i = pc_reg; target = 64'h0;
        mem_cnt = 0; mem_addr = 64'h0; mem_err = 1'b0; cyc = 0; lat = 1;
        m_started = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_pend = 64'h0;

        // 1: streaming with a 1-cycle memory
        do_reset();
        for (int i = 0; i < 8; i++) cycle();
        chk("p1_nreq", 64'(req_log.size()), 64'd4);
        chk("p1_ncons", 64'(cons_log.size()), 64'd3);
        if (req_log.size() >= 3 && cons_log.size() >= 3) begin
            chk("p1_req0", req_log[0], 64'h0);
            chk("p1_req1", req_log[1], 64'h4);
            chk("p1_req2", req_log[2], 64'h8);
            chk("p1_gap01", 64'(req_cyc[1] - req_cyc[0]), 64'd2);
            chk("p1_gap12", 64'(req_cyc[2] - req_cyc[1]), 64'd2);
            chk("p1_cons0", cons_log[0], 64'h0);
            chk("p1_cons1", cons_log[1], 64'h4);
            chk("p1_cons2", cons_log[2], 64'h8);
        end

        // 2: decode back-pressure fills the queue
        do_reset();
        if_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        chk("p2_full_stall", 64'(s_stall), 64'd1);
        chk("p2_full_noreq", 64'(s_req), 64'd0);
        chk("p2_head_pc", s_ifpc, 64'h0);
        chk("p2_nreq", 64'(req_log.size()), 64'd2);
        if_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("p2_ncons_ok", 64'(cons_log.size() >= 2 && req_log.size() >= 3), 64'd1);
        if (cons_log.size() >= 2 && req_log.size() >= 3) begin
            chk("p2_cons0", cons_log[0], 64'h0);
            chk("p2_cons1", cons_log[1], 64'h4);
            chk("p2_resume", req_log[2], 64'h8);
        end

        // 3: memory not ready for 3 cycles at 0x4
        do_reset();
        for (int i = 0; i < 3; i++) cycle();
        imem_req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("p3_req_held", 64'(s_req), 64'd1);
            chk("p3_addr_held", s_addr, 64'h4);
            chk("p3_stall_held", 64'(s_stall), 64'd1);
        end
        imem_req_ready_i = 1'b1;
        cycle();
        chk("p3_hs_addr", req_log[req_log.size() - 1], 64'h4);

        // 4: flush while waiting, stale response dropped
        do_reset();
        lat = 3;
        cycle();
        cycle();
        flush_i = 1'b1; target = 64'h100;
        cycle();
        flush_i = 1'b0;
        cycle();
        chk("p4_drop_stall", 64'(s_stall), 64'd1);
        chk("p4_drop_noreq", 64'(s_req), 64'd0);
        cycle();
        chk("p4_q_empty", 64'(s_ifv), 64'd0);
        cycle();
        chk("p4_new_req", 64'(s_req), 64'd1);
        chk("p4_new_addr", s_addr, 64'h100);

        // 5: flush coincident with the response
        do_reset();
        cycle();
        cycle();
        flush_i = 1'b1; target = 64'h200;
        cycle();
        flush_i = 1'b0;
        cycle();
        chk("p5_req_now", 64'(s_req), 64'd1);
        chk("p5_addr", s_addr, 64'h200);
        chk("p5_not_queued", 64'(s_ifv), 64'd0);

        // 6: misaligned PC and access error
        do_reset();
        if_ready_i = 1'b0;
        cycle();
        flush_i = 1'b1; target = 64'h102;
        cycle();
        flush_i = 1'b0;
        cycle();
        flush_i = 1'b1; target = 64'h200; err_knob = 1'b1;
        cycle();
        chk("p6_mis_valid", 64'(s_ifv), 64'd1);
        chk("p6_mis_pc", s_ifpc, 64'h102);
        chk("p6_mis_instr", 64'(s_instr), 64'd0);
        chk("p6_mis_fault", 64'(s_fault), 64'd1);
        flush_i = 1'b0;
        cycle();
        cycle();
        cycle();
        chk("p6_err_pc", s_ifpc, 64'h200);
        chk("p6_err_instr", 64'(s_instr), 64'd0);
        chk("p6_err_fault", 64'(s_fault), 64'd1);

        // 7: randomized traffic against the reference model
        do_reset();
        rand_err = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready_i = ($urandom_range(0, 3) != 0);
            if_ready_i       = ($urandom_range(0, 2) != 0);
            lat              = $urandom_range(1, 3);
            flush_i          = (mem_cnt != 1) && ($urandom_range(0, 19) == 0);
            target           = 64'($urandom_range(0, 255)) * 64'd4 +
                               (($urandom_range(0, 7) == 0) ? 64'd2 : 64'd0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
